en_shift_reg: RTL and testbench
===============================

EN_SHIFT_REG -- requirements
Module: en_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, bit width of each stage.
REQ-002 The block SHALL have parameter DEPTH, default 1, number of stages (legal range 1..64).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: shift enable.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear.
REQ-007 The block SHALL have port d, input, WIDTH bits: data into stage 0.
REQ-008 The block SHALL have port q, output, WIDTH bits: contents of stage DEPTH-1.
REQ-009 The block SHALL have port q_valid, output, 1 bit: stage DEPTH-1 holds data shifted in since the last reset or clear.
REQ-010 The block SHALL have port fill, output, $clog2(DEPTH+1) bits: count of valid stages.

Function
REQ-011 Stages s[0..DEPTH-1] SHALL be registers; q SHALL equal s[DEPTH-1] directly, with no combinational path from d or en to q.
REQ-012 On a rising edge with en=1 and clr=0, s[0]<=d and s[i]<=s[i-1] for i=1..DEPTH-1, all in the same edge.
REQ-013 On a rising edge with en=0 and clr=0, all stages and fill SHALL hold.
REQ-014 Latency SHALL be DEPTH enabled edges: a value sampled on d at enabled edge k appears on q after enabled edge k+DEPTH-1; non-enabled edges do not count.
REQ-015 With WIDTH=1 and DEPTH=1, behaviour SHALL be exactly an enabled D flip-flop: q<=d when en=1, hold otherwise.
REQ-016 fill SHALL increment by 1 on each enabled edge and saturate at DEPTH with no wrap-around.
REQ-017 q_valid SHALL be 1 exactly when fill==DEPTH.
REQ-018 clr=1 on a rising edge SHALL set all stages to 0 and fill to 0, taking priority over en and load.
REQ-019 The block SHALL treat an X or Z value on en or clr as a design error; the bench flags it and the RTL does not special-case it.

Reset
REQ-020 When rst_n is low, all stages, q, fill and q_valid SHALL become 0 immediately, without waiting for a clock edge.
REQ-021 Reset asserted mid-shift SHALL discard all data in flight; the first enabled edge after deassertion SHALL behave as the first after power-up (fill becomes 1).
REQ-022 Deassertion of rst_n SHALL take effect at the first rising edge of clk at which rst_n is high.

Configuration
REQ-023 The macro EN_SHIFT_REG_PARALLEL_LOAD_EN SHALL control the parallel-load feature.
REQ-024 When EN_SHIFT_REG_PARALLEL_LOAD_EN is defined, the block SHALL add input load (1 bit) and input pdata (WIDTH*DEPTH bits, stage i at bits [i*WIDTH +: WIDTH]).
REQ-025 When EN_SHIFT_REG_PARALLEL_LOAD_EN is defined, load=1 with clr=0 SHALL write every stage from pdata and set fill to DEPTH, with priority over en.
REQ-026 Edge priority with EN_SHIFT_REG_PARALLEL_LOAD_EN defined SHALL be clr > load > en > hold.
REQ-027 When EN_SHIFT_REG_PARALLEL_LOAD_EN is undefined, the load and pdata ports and their logic SHALL be absent, and behaviour SHALL be REQ-011..022 only.

Verification
REQ-028 Scenario, single flip-flop: WIDTH=1, DEPTH=1, drive {d,en}=00,00,00,10,10,10,01,01,01,11,11 then hold -> q sequence 0,0,0,0,0,0,0,0,0,1,1,1,... with no X after reset.
REQ-029 Scenario, latency: WIDTH=8, DEPTH=4, en=1, d=0x11,0x22,0x33,0x44,0x55 -> q=0x11 and q_valid=1 after the 4th edge, q=0x22 after the 5th; fill reads 1,2,3,4,4.
REQ-030 Scenario, stall: same configuration, en=0 for 3 edges mid-stream -> q and fill frozen, and the output sequence resumes unchanged once en=1.
REQ-031 Scenario, clear: clr=1 and en=1 on the same edge with fill=4 -> all stages 0, fill=0, q_valid=0; the next enabled edge gives fill=1.
REQ-032 Scenario, async reset: drop rst_n between edges while fill=3 -> q=0 and fill=0 before the next edge; after release, the 4-edge latency restarts.
REQ-033 Scenario, parallel load (EN_SHIFT_REG_PARALLEL_LOAD_EN defined): pdata=0x44332211, load=1, en=1 -> q=0x44, fill=4; next enabled edge with d=0x99 -> q=0x33 and s[0]=0x99.

Source files
------------

// File: rtl/en_shift_reg.sv
// rtl/en_shift_reg.sv - enable-gated shift register with fill count and q_valid.
// Optional parallel load is compiled in when EN_SHIFT_REG_PARALLEL_LOAD_EN is defined.
module en_shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         clr,
`ifdef EN_SHIFT_REG_PARALLEL_LOAD_EN
  input  logic                         load,
  input  logic [WIDTH*DEPTH-1:0]       pdata,
`endif
  input  logic [WIDTH-1:0]             d,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic [$clog2(DEPTH+1)-1:0]   fill
);

  localparam int            FW   = $clog2(DEPTH+1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  // Packed so stage i lines up with pdata[i*WIDTH +: WIDTH].
  logic [DEPTH-1:0][WIDTH-1:0] r_stages;
  logic [FW-1:0]               r_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stages <= '0;
      r_fill   <= '0;
    end else if (clr) begin
      r_stages <= '0;
      r_fill   <= '0;
    end
`ifdef EN_SHIFT_REG_PARALLEL_LOAD_EN
    else if (load) begin
      r_stages <= pdata;
      r_fill   <= FULL;
    end
`endif
    else if (en) begin
      r_stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stages[i] <= r_stages[i-1];
      end
      if (r_fill != FULL) begin
        r_fill <= r_fill + FW'(1);
      end
    end
  end

  assign q       = r_stages[DEPTH-1];
  assign fill    = r_fill;
  assign q_valid = (r_fill == FULL);

endmodule

// File: tb/tb_en_shift_reg.sv
// tb/tb_en_shift_reg.sv - bench for en_shift_reg: a 1x1 and an 8x4 instance against
// constant tables, hand sequences and a queue-based reference model under random stimulus.
module tb_en_shift_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       d1, en1, clr1, q1, qv1;
  logic [0:0] fill1;
  logic [7:0] d4, q4;
  logic       en4, clr4, qv4;
  logic [2:0] fill4;
`ifdef EN_SHIFT_REG_PARALLEL_LOAD_EN
  logic        load1, load4;
  logic [0:0]  pdata1;
  logic [31:0] pdata4;
`endif

  int checks = 0;
  int errors = 0;

  // Reference: last value shifted into the 1x1 part, and the history of accepted
  // words (oldest first, at most DEPTH) for the 8x4 part.
  logic       m_q1;
  logic       m_fill1;
  logic [7:0] hist[$];

  always #5 clk = ~clk;

  en_shift_reg #(.WIDTH(1), .DEPTH(1)) u_dff (
    .clk(clk), .rst_n(rst_n), .en(en1), .clr(clr1),
`ifdef EN_SHIFT_REG_PARALLEL_LOAD_EN
    .load(load1), .pdata(pdata1),
`endif
    .d(d1), .q(q1), .q_valid(qv1), .fill(fill1)
  );

  en_shift_reg #(.WIDTH(8), .DEPTH(4)) u_sr4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .clr(clr4),
`ifdef EN_SHIFT_REG_PARALLEL_LOAD_EN
    .load(load4), .pdata(pdata4),
`endif
    .d(d4), .q(q4), .q_valid(qv4), .fill(fill4)
  );

  typedef struct {
    logic d;
    logic en;
    logic exp_q;
  } v1_t;

  typedef struct {
    logic [7:0] d;
    logic       en;
    logic       clr;
    logic [7:0] exp_q;
    logic       exp_v;
    logic [2:0] exp_f;
  } v4_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_all();
    en1 = 1'b0; clr1 = 1'b0; d1 = 1'b0;
    en4 = 1'b0; clr4 = 1'b0; d4 = 8'h00;
`ifdef EN_SHIFT_REG_PARALLEL_LOAD_EN
    load1 = 1'b0; pdata1 = 1'b0; load4 = 1'b0; pdata4 = 32'h0;
`endif
  endtask

  task automatic model_reset();
    m_q1 = 1'b0;
    m_fill1 = 1'b0;
    hist.delete();
  endtask

  // One clock: update the model from the inputs seen at the edge, then settle.
  task automatic tick();
    @(posedge clk);
    if ($isunknown({en1, clr1, en4, clr4})) begin
      errors++;
      $display("FAIL xz_ctrl en/clr unknown at %0t", $time);
    end
    if (rst_n) begin
      if (clr1) begin
        m_q1 = 1'b0; m_fill1 = 1'b0;
      end
`ifdef EN_SHIFT_REG_PARALLEL_LOAD_EN
      else if (load1) begin
        m_q1 = pdata1[0]; m_fill1 = 1'b1;
      end
`endif
      else if (en1) begin
        m_q1 = d1; m_fill1 = 1'b1;
      end

      if (clr4) begin
        hist.delete();
      end
`ifdef EN_SHIFT_REG_PARALLEL_LOAD_EN
      else if (load4) begin
        hist.delete();
        for (int i = 3; i >= 0; i--) hist.push_back(pdata4[i*8 +: 8]);
      end
`endif
      else if (en4) begin
        hist.push_back(d4);
        if (hist.size() > 4) void'(hist.pop_front());
      end
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] eq;
    eq = (hist.size() == 4) ? hist[0] : 8'h00;
    chk({tag, ".q1"},    32'(q1),    32'(m_q1));
    chk({tag, ".fill1"}, 32'(fill1), 32'(m_fill1));
    chk({tag, ".qv1"},   32'(qv1),   32'(m_fill1));
    chk({tag, ".q4"},    32'(q4),    32'(eq));
    chk({tag, ".fill4"}, 32'(fill4), 32'(hist.size()));
    chk({tag, ".qv4"},   32'(qv4),   32'(hist.size() == 4));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    v1_t t1[12];
    v4_t t4[12];

    t1[0]  = '{1'b0, 1'b0, 1'b0};
    t1[1]  = '{1'b0, 1'b0, 1'b0};
    t1[2]  = '{1'b0, 1'b0, 1'b0};
    t1[3]  = '{1'b1, 1'b0, 1'b0};
    t1[4]  = '{1'b1, 1'b0, 1'b0};
    t1[5]  = '{1'b1, 1'b0, 1'b0};
    t1[6]  = '{1'b0, 1'b1, 1'b0};
    t1[7]  = '{1'b0, 1'b1, 1'b0};
    t1[8]  = '{1'b0, 1'b1, 1'b0};
    t1[9]  = '{1'b1, 1'b1, 1'b1};
    t1[10] = '{1'b1, 1'b1, 1'b1};
    t1[11] = '{1'b0, 1'b0, 1'b1};

    t4[0]  = '{8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1};
    t4[1]  = '{8'h22, 1'b1, 1'b0, 8'h00, 1'b0, 3'd2};
    t4[2]  = '{8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 3'd3};
    t4[3]  = '{8'h44, 1'b1, 1'b0, 8'h11, 1'b1, 3'd4};
    t4[4]  = '{8'h55, 1'b1, 1'b0, 8'h22, 1'b1, 3'd4};
    t4[5]  = '{8'hA0, 1'b0, 1'b0, 8'h22, 1'b1, 3'd4};
    t4[6]  = '{8'hA1, 1'b0, 1'b0, 8'h22, 1'b1, 3'd4};
    t4[7]  = '{8'hA2, 1'b0, 1'b0, 8'h22, 1'b1, 3'd4};
    t4[8]  = '{8'h66, 1'b1, 1'b0, 8'h33, 1'b1, 3'd4};
    t4[9]  = '{8'h77, 1'b1, 1'b0, 8'h44, 1'b1, 3'd4};
    t4[10] = '{8'h88, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0};
    t4[11] = '{8'h99, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1};

    idle_all();
    model_reset();

    // Asynchronous reset takes effect before the first clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      d1 = t1[i].d; en1 = t1[i].en;
      tick();
      chk($sformatf("dff_tbl[%0d].q", i), 32'(q1), 32'(t1[i].exp_q));
    end
    idle_all();

    for (int i = 0; i < 12; i++) begin
      d4 = t4[i].d; en4 = t4[i].en; clr4 = t4[i].clr;
      tick();
      chk($sformatf("sr4_tbl[%0d].q", i),    32'(q4),    32'(t4[i].exp_q));
      chk($sformatf("sr4_tbl[%0d].qv", i),   32'(qv4),   32'(t4[i].exp_v));
      chk($sformatf("sr4_tbl[%0d].fill", i), 32'(fill4), 32'(t4[i].exp_f));
    end
    idle_all();
    check_all("after_tbl");

    // Reset dropped between edges with fill=3 discards everything in flight.
    en4 = 1'b1;
    d4 = 8'hA1; tick();
    d4 = 8'hA2; tick();
    chk("arst.fill_before", 32'(fill4), 32'd3);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.q_now",    32'(q4),    32'h0);
    chk("arst.fill_now", 32'(fill4), 32'h0);
    chk("arst.qv_now",   32'(qv4),   32'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d4 = 8'hB1 + 8'(i);
      tick();
      check_all($sformatf("arst.relat[%0d]", i));
    end
    chk("arst.q_latency", 32'(q4), 32'hB1);
    idle_all();

`ifdef EN_SHIFT_REG_PARALLEL_LOAD_EN
    pdata4 = 32'h44332211; load4 = 1'b1; en4 = 1'b1; d4 = 8'hEE;
    tick();
    chk("pload.q",    32'(q4),    32'h44);
    chk("pload.fill", 32'(fill4), 32'd4);
    load4 = 1'b0; d4 = 8'h99;
    tick();
    chk("pload.q_next", 32'(q4), 32'h33);
    d4 = 8'h00;
    repeat (3) tick();
    chk("pload.s0", 32'(q4), 32'h99);
    idle_all();
`endif

    for (int n = 0; n < 400; n++) begin
      d1 = 1'($urandom);
      en1 = ($urandom_range(0, 9) < 7);
      clr1 = ($urandom_range(0, 19) == 0);
      d4 = 8'($urandom);
      en4 = ($urandom_range(0, 9) < 7);
      clr4 = ($urandom_range(0, 24) == 0);
`ifdef EN_SHIFT_REG_PARALLEL_LOAD_EN
      load1 = ($urandom_range(0, 19) == 0);
      pdata1 = 1'($urandom);
      load4 = ($urandom_range(0, 19) == 0);
      pdata4 = $urandom;
`endif
      tick();
      check_all($sformatf("rnd[%0d]", n));
      if (n == 200) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rnd.arst");
        @(negedge clk) rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
